pipe_hazard_ctrl: RTL and testbench

Pipeline hazard and stall controller for the in-order RV32 core. It watches the ID, EX and MEM stage registers. It drives the hold, bubble and flush controls for the IF/ID, ID/EX and EX/MEM pipeline registers, including the EX→MEM register that carries wmask/rs1/rs2. It sequences three events: load-use bubbles, multi-cycle data-memory waits, and taken-branch squashes. It also keeps a stall-cycle performance counter and a memory-timeout watchdog.

---
 rtl/pipe_hazard_ctrl.sv | 175 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller for the in-order RV32 pipeline: load-use bubbles,
// data-memory wait freezes, taken-branch squashes, stall counter and wait watchdog.
module pipe_hazard_ctrl #(
   parameter int unsigned LOAD_USE_CYCLES = 1,
   parameter int unsigned POSTED_STORES   = 1,
   parameter int unsigned TIMEOUT         = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic        id_use_rs1,
   input  logic        id_use_rs2,
   input  logic        ex_valid,
   input  logic [4:0]  ex_rd,
   input  logic        ex_reg_write,
   input  logic        ex_is_load,
   input  logic        ex_branch_taken,
   input  logic        mem_req,
   input  logic [3:0]  mem_wmask,
   input  logic        mem_ack,
   output logic        stall_if,
   output logic        stall_id,
   output logic        stall_ex,
   output logic        bubble_ex,
   output logic        flush_id,
   output logic        flush_ex,
   output logic [1:0]  state,
   output logic [31:0] stall_cycles,
   output logic        mem_timeout
);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_LU_STALL = 2'd1,
      ST_MEM_WAIT = 2'd2
   } state_t;

   localparam int unsigned    WCW         = $clog2(TIMEOUT + 1);
   localparam logic [2:0]     LU_REM_INIT = 3'(LOAD_USE_CYCLES - 1);
   localparam logic [WCW-1:0] WAIT_LAST   = WCW'(TIMEOUT - 1);
   localparam logic [WCW-1:0] WAIT_MAX    = WCW'(TIMEOUT);

   state_t         state_r;
   logic [2:0]     remaining_r;
   logic           ret_lu_r;
   logic [WCW-1:0] wait_cnt_r;
   logic [31:0]    stall_cycles_r;
   logic           mem_timeout_r;

   logic   store_posted_s;
   logic   freeze_s;
   logic   lu_hit_s;
   logic   br_s;
   logic   eff_lu_s;
   logic   stall_fe_s;
   logic   stall_ex_s;
   logic   bubble_s;
   logic   flush_s;
   state_t state_nxt_s;
   logic [2:0] remaining_nxt_s;
   logic   ret_lu_nxt_s;

   assign store_posted_s = (POSTED_STORES != 32'd0) && (mem_wmask != 4'd0);
   assign freeze_s       = mem_req && !mem_ack && !store_posted_s;
   assign lu_hit_s       = ex_valid && ex_is_load && ex_reg_write && (ex_rd != 5'd0) &&
                           ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                            (id_use_rs2 && (id_rs2 == ex_rd)));
   assign br_s           = ex_valid && ex_branch_taken;
   // A MEM_WAIT that interrupted a load-use sequence resumes it once unfrozen.
   assign eff_lu_s       = (state_r == ST_LU_STALL) || ((state_r == ST_MEM_WAIT) && ret_lu_r);

   // Pipeline controls and next-state selection, priority freeze > branch > load-use.
   always_comb begin
      stall_fe_s      = 1'b0;
      stall_ex_s      = 1'b0;
      bubble_s        = 1'b0;
      flush_s         = 1'b0;
      state_nxt_s     = state_r;
      remaining_nxt_s = remaining_r;
      ret_lu_nxt_s    = ret_lu_r;
      if (rst) begin
         state_nxt_s     = ST_RUN;
         remaining_nxt_s = 3'd0;
         ret_lu_nxt_s    = 1'b0;
      end else if (freeze_s) begin
         stall_fe_s  = 1'b1;
         stall_ex_s  = 1'b1;
         state_nxt_s = ST_MEM_WAIT;
         if (state_r != ST_MEM_WAIT) begin
            ret_lu_nxt_s = (state_r == ST_LU_STALL);
         end else begin
            ret_lu_nxt_s = ret_lu_r;
         end
      end else if (br_s) begin
         flush_s         = 1'b1;
         state_nxt_s     = ST_RUN;
         remaining_nxt_s = 3'd0;
         ret_lu_nxt_s    = 1'b0;
      end else if (eff_lu_s) begin
         stall_fe_s   = 1'b1;
         bubble_s     = 1'b1;
         ret_lu_nxt_s = 1'b0;
         if (remaining_r <= 3'd1) begin
            state_nxt_s     = ST_RUN;
            remaining_nxt_s = 3'd0;
         end else begin
            state_nxt_s     = ST_LU_STALL;
            remaining_nxt_s = remaining_r - 3'd1;
         end
      end else if (lu_hit_s) begin
         stall_fe_s   = 1'b1;
         bubble_s     = 1'b1;
         ret_lu_nxt_s = 1'b0;
         if (LOAD_USE_CYCLES > 32'd1) begin
            state_nxt_s     = ST_LU_STALL;
            remaining_nxt_s = LU_REM_INIT;
         end else begin
            state_nxt_s     = ST_RUN;
            remaining_nxt_s = 3'd0;
         end
      end else begin
         state_nxt_s     = ST_RUN;
         remaining_nxt_s = 3'd0;
         ret_lu_nxt_s    = 1'b0;
      end
   end

   // State, watchdog and performance counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r        <= ST_RUN;
         remaining_r    <= 3'd0;
         ret_lu_r       <= 1'b0;
         wait_cnt_r     <= '0;
         stall_cycles_r <= 32'd0;
         mem_timeout_r  <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         remaining_r <= remaining_nxt_s;
         ret_lu_r    <= ret_lu_nxt_s;
         if ((state_r == ST_MEM_WAIT) && freeze_s) begin
            if (wait_cnt_r != WAIT_MAX) begin
               wait_cnt_r <= wait_cnt_r + WCW'(1);
            end else begin
               wait_cnt_r <= wait_cnt_r;
            end
            if (wait_cnt_r == WAIT_LAST) begin
               mem_timeout_r <= 1'b1;
            end else begin
               mem_timeout_r <= mem_timeout_r;
            end
         end else begin
            wait_cnt_r    <= '0;
            mem_timeout_r <= mem_timeout_r;
         end
         if (stall_fe_s && (stall_cycles_r != 32'hFFFF_FFFF)) begin
            stall_cycles_r <= stall_cycles_r + 32'd1;
         end else begin
            stall_cycles_r <= stall_cycles_r;
         end
      end
   end

   assign stall_if     = stall_fe_s;
   assign stall_id     = stall_fe_s;
   assign stall_ex     = stall_ex_s;
   assign bubble_ex    = bubble_s;
   assign flush_id     = flush_s;
   assign flush_ex     = flush_s;
   assign state        = state_r;
   assign stall_cycles = stall_cycles_r;
   assign mem_timeout  = mem_timeout_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: instance A uses default parameters,
// instance B uses LOAD_USE_CYCLES=3, POSTED_STORES=0, TIMEOUT=8.
module tb_pipe_hazard_ctrl;

   logic clk, rst;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic id_use_rs1, id_use_rs2, ex_valid, ex_reg_write, ex_is_load, ex_branch_taken;
   logic mem_req, mem_ack;
   logic [3:0] mem_wmask;

   logic a_stall_if, a_stall_id, a_stall_ex, a_bubble_ex, a_flush_id, a_flush_ex, a_mem_timeout;
   logic b_stall_if, b_stall_id, b_stall_ex, b_bubble_ex, b_flush_id, b_flush_ex, b_mem_timeout;
   logic [1:0] a_state, b_state;
   logic [31:0] a_stall_cycles, b_stall_cycles;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string      tag;
      int         cyc;
      logic [7:0] a;
      logic [7:0] b;
   } exp_t;
   exp_t sb[$];

   // Packed view: {stall_if, stall_id, stall_ex, bubble_ex, flush_id, flush_ex, state}
   localparam logic [7:0] Z0   = 8'b0000_0000;
   localparam logic [7:0] W2   = 8'b0000_0010;
   localparam logic [7:0] LU0  = 8'b1101_0000;
   localparam logic [7:0] LU1  = 8'b1101_0001;
   localparam logic [7:0] LU2  = 8'b1101_0010;
   localparam logic [7:0] FRZ0 = 8'b1110_0000;
   localparam logic [7:0] FRZ1 = 8'b1110_0001;
   localparam logic [7:0] FRZ2 = 8'b1110_0010;
   localparam logic [7:0] BR0  = 8'b0000_1100;
   localparam logic [7:0] BR2  = 8'b0000_1110;

   localparam int C_IDLE = 0, C_LU = 1, C_LU_RD0 = 2, C_LU_NOUSE = 3, C_LU_RS2 = 4;
   localparam int C_BR_LU = 5, C_ML = 6, C_MLA = 7, C_ST = 8, C_STA = 9;
   localparam int C_MLBR = 10, C_MLBRA = 11, C_ALL = 12;

   pipe_hazard_ctrl u_a (
      .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_valid(ex_valid),
      .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load),
      .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_wmask(mem_wmask),
      .mem_ack(mem_ack), .stall_if(a_stall_if), .stall_id(a_stall_id),
      .stall_ex(a_stall_ex), .bubble_ex(a_bubble_ex), .flush_id(a_flush_id),
      .flush_ex(a_flush_ex), .state(a_state), .stall_cycles(a_stall_cycles),
      .mem_timeout(a_mem_timeout)
   );

   pipe_hazard_ctrl #(.LOAD_USE_CYCLES(3), .POSTED_STORES(0), .TIMEOUT(8)) u_b (
      .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_valid(ex_valid),
      .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load),
      .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_wmask(mem_wmask),
      .mem_ack(mem_ack), .stall_if(b_stall_if), .stall_id(b_stall_id),
      .stall_ex(b_stall_ex), .bubble_ex(b_bubble_ex), .flush_id(b_flush_id),
      .flush_ex(b_flush_ex), .state(b_state), .stall_cycles(b_stall_cycles),
      .mem_timeout(b_mem_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] obs_a();
      return {a_stall_if, a_stall_id, a_stall_ex, a_bubble_ex, a_flush_id, a_flush_ex, a_state};
   endfunction

   function automatic logic [7:0] obs_b();
      return {b_stall_if, b_stall_id, b_stall_ex, b_bubble_ex, b_flush_id, b_flush_ex, b_state};
   endfunction

   task automatic apply(input int code);
      id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
      ex_valid = 1'b0; ex_rd = 5'd0; ex_reg_write = 1'b0; ex_is_load = 1'b0;
      ex_branch_taken = 1'b0; mem_req = 1'b0; mem_wmask = 4'd0; mem_ack = 1'b0;
      if (code inside {C_LU, C_LU_RD0, C_LU_NOUSE, C_LU_RS2, C_BR_LU, C_ALL}) begin
         ex_valid = 1'b1; ex_is_load = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd5;
         id_rs1 = 5'd5; id_use_rs1 = 1'b1;
      end
      case (code)
         C_LU_RD0:   begin ex_rd = 5'd0; id_rs1 = 5'd0; end
         C_LU_NOUSE: id_use_rs1 = 1'b0;
         C_LU_RS2:   begin id_rs1 = 5'd0; id_use_rs1 = 1'b0; id_rs2 = 5'd5; id_use_rs2 = 1'b1; end
         C_BR_LU:    ex_branch_taken = 1'b1;
         C_ML:       mem_req = 1'b1;
         C_MLA:      begin mem_req = 1'b1; mem_ack = 1'b1; end
         C_ST:       begin mem_req = 1'b1; mem_wmask = 4'b1111; end
         C_STA:      begin mem_req = 1'b1; mem_wmask = 4'b1111; mem_ack = 1'b1; end
         C_MLBR:     begin mem_req = 1'b1; ex_valid = 1'b1; ex_branch_taken = 1'b1; end
         C_MLBRA:    begin mem_req = 1'b1; mem_ack = 1'b1; ex_valid = 1'b1; ex_branch_taken = 1'b1; end
         C_ALL:      begin ex_branch_taken = 1'b1; mem_req = 1'b1; mem_wmask = 4'b0011; end
         default:    ;
      endcase
   endtask

   task automatic do_reset();
      rst = 1'b1;
      apply(C_IDLE);
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      exp_t e;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         apply(i < 2 ? C_ALL : C_IDLE);
         if (i == 2) rst = 1'b0;
         e.tag = "reset"; e.cyc = i; e.a = Z0; e.b = Z0;
         sb.push_back(e);
         @(negedge clk);
         e = sb.pop_front();
         checks += 4;
         if (obs_a() !== e.a) begin errors++; $display("FAIL %s cyc%0d inst_a got %b exp %b", e.tag, e.cyc, obs_a(), e.a); end
         if (obs_b() !== e.b) begin errors++; $display("FAIL %s cyc%0d inst_b got %b exp %b", e.tag, e.cyc, obs_b(), e.b); end
         if (a_stall_cycles !== 32'd0 || b_stall_cycles !== 32'd0) begin
            errors++; $display("FAIL reset_stall_cycles cyc%0d got a=%0d b=%0d exp 0", i, a_stall_cycles, b_stall_cycles);
         end
         if (a_mem_timeout !== 1'b0 || b_mem_timeout !== 1'b0) begin
            errors++; $display("FAIL reset_mem_timeout cyc%0d got a=%b b=%b exp 0", i, a_mem_timeout, b_mem_timeout);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_load_use();
      int stim[9];
      logic [7:0] ea[9], eb[9];
      exp_t e;
      stim = '{C_LU, C_IDLE, C_IDLE, C_IDLE, C_LU_RD0, C_LU_NOUSE, C_LU_RS2, C_IDLE, C_IDLE};
      ea   = '{LU0, Z0, Z0, Z0, Z0, Z0, LU0, Z0, Z0};
      eb   = '{LU0, LU1, LU1, Z0, Z0, Z0, LU0, LU1, LU1};
      do_reset();
      for (int i = 0; i < 9; i++) begin
         apply(stim[i]);
         e.tag = "load_use"; e.cyc = i; e.a = ea[i]; e.b = eb[i];
         sb.push_back(e);
         @(negedge clk);
         e = sb.pop_front();
         checks += 2;
         if (obs_a() !== e.a) begin errors++; $display("FAIL %s cyc%0d inst_a got %b exp %b", e.tag, e.cyc, obs_a(), e.a); end
         if (obs_b() !== e.b) begin errors++; $display("FAIL %s cyc%0d inst_b got %b exp %b", e.tag, e.cyc, obs_b(), e.b); end
         @(posedge clk); #1;
      end
      checks += 2;
      if (a_stall_cycles !== 32'd2) begin errors++; $display("FAIL load_use stall_cycles_a got %0d exp 2", a_stall_cycles); end
      if (b_stall_cycles !== 32'd6) begin errors++; $display("FAIL load_use stall_cycles_b got %0d exp 6", b_stall_cycles); end
   endtask

   task automatic test_mem_wait();
      int stim[7];
      logic [7:0] ex[7];
      exp_t e;
      stim = '{C_ML, C_ML, C_ML, C_MLA, C_IDLE, C_MLA, C_IDLE};
      ex   = '{FRZ0, FRZ2, FRZ2, W2, Z0, Z0, Z0};
      do_reset();
      for (int i = 0; i < 7; i++) begin
         apply(stim[i]);
         e.tag = "mem_wait"; e.cyc = i; e.a = ex[i]; e.b = ex[i];
         sb.push_back(e);
         @(negedge clk);
         e = sb.pop_front();
         checks += 2;
         if (obs_a() !== e.a) begin errors++; $display("FAIL %s cyc%0d inst_a got %b exp %b", e.tag, e.cyc, obs_a(), e.a); end
         if (obs_b() !== e.b) begin errors++; $display("FAIL %s cyc%0d inst_b got %b exp %b", e.tag, e.cyc, obs_b(), e.b); end
         @(posedge clk); #1;
      end
      checks += 2;
      if (a_stall_cycles !== 32'd3 || b_stall_cycles !== 32'd3) begin
         errors++; $display("FAIL mem_wait stall_cycles got a=%0d b=%0d exp 3", a_stall_cycles, b_stall_cycles);
      end
      if (a_mem_timeout !== 1'b0 || b_mem_timeout !== 1'b0) begin
         errors++; $display("FAIL mem_wait mem_timeout got a=%b b=%b exp 0", a_mem_timeout, b_mem_timeout);
      end
   endtask

   task automatic test_posted_store();
      int stim[5];
      logic [7:0] ea[5], eb[5];
      exp_t e;
      stim = '{C_ST, C_ST, C_ST, C_STA, C_IDLE};
      ea   = '{Z0, Z0, Z0, Z0, Z0};
      eb   = '{FRZ0, FRZ2, FRZ2, W2, Z0};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         apply(stim[i]);
         e.tag = "posted_store"; e.cyc = i; e.a = ea[i]; e.b = eb[i];
         sb.push_back(e);
         @(negedge clk);
         e = sb.pop_front();
         checks += 2;
         if (obs_a() !== e.a) begin errors++; $display("FAIL %s cyc%0d inst_a got %b exp %b", e.tag, e.cyc, obs_a(), e.a); end
         if (obs_b() !== e.b) begin errors++; $display("FAIL %s cyc%0d inst_b got %b exp %b", e.tag, e.cyc, obs_b(), e.b); end
         @(posedge clk); #1;
      end
      checks += 2;
      if (a_stall_cycles !== 32'd0) begin errors++; $display("FAIL posted_store stall_cycles_a got %0d exp 0", a_stall_cycles); end
      if (b_stall_cycles !== 32'd3) begin errors++; $display("FAIL posted_store stall_cycles_b got %0d exp 3", b_stall_cycles); end
   endtask

   task automatic test_overlap();
      int stim[12];
      logic [7:0] ea[12], eb[12];
      exp_t e;
      stim = '{C_BR_LU, C_IDLE, C_MLBR, C_MLBR, C_MLBRA, C_IDLE, C_LU, C_ML, C_ML, C_MLA, C_IDLE, C_IDLE};
      ea   = '{BR0, Z0, FRZ0, FRZ2, BR2, Z0, LU0, FRZ0, FRZ2, W2, Z0, Z0};
      eb   = '{BR0, Z0, FRZ0, FRZ2, BR2, Z0, LU0, FRZ1, FRZ2, LU2, LU1, Z0};
      do_reset();
      for (int i = 0; i < 12; i++) begin
         apply(stim[i]);
         e.tag = "overlap"; e.cyc = i; e.a = ea[i]; e.b = eb[i];
         sb.push_back(e);
         @(negedge clk);
         e = sb.pop_front();
         checks += 2;
         if (obs_a() !== e.a) begin errors++; $display("FAIL %s cyc%0d inst_a got %b exp %b", e.tag, e.cyc, obs_a(), e.a); end
         if (obs_b() !== e.b) begin errors++; $display("FAIL %s cyc%0d inst_b got %b exp %b", e.tag, e.cyc, obs_b(), e.b); end
         @(posedge clk); #1;
      end
      checks += 2;
      if (a_stall_cycles !== 32'd5) begin errors++; $display("FAIL overlap stall_cycles_a got %0d exp 5", a_stall_cycles); end
      if (b_stall_cycles !== 32'd7) begin errors++; $display("FAIL overlap stall_cycles_b got %0d exp 7", b_stall_cycles); end
   endtask

   task automatic test_watchdog();
      exp_t e;
      logic exp_to;
      do_reset();
      for (int i = 0; i < 12; i++) begin
         apply(i < 10 ? C_ML : (i == 10 ? C_MLA : C_IDLE));
         e.tag = "watchdog"; e.cyc = i;
         e.a = (i == 0) ? FRZ0 : (i < 10 ? FRZ2 : (i == 10 ? W2 : Z0));
         e.b = e.a;
         exp_to = (i >= 9);
         sb.push_back(e);
         @(negedge clk);
         e = sb.pop_front();
         checks += 4;
         if (obs_a() !== e.a) begin errors++; $display("FAIL %s cyc%0d inst_a got %b exp %b", e.tag, e.cyc, obs_a(), e.a); end
         if (obs_b() !== e.b) begin errors++; $display("FAIL %s cyc%0d inst_b got %b exp %b", e.tag, e.cyc, obs_b(), e.b); end
         if (b_mem_timeout !== exp_to) begin errors++; $display("FAIL watchdog_b cyc%0d got %b exp %b", i, b_mem_timeout, exp_to); end
         if (a_mem_timeout !== 1'b0) begin errors++; $display("FAIL watchdog_a cyc%0d got %b exp 0", i, a_mem_timeout); end
         @(posedge clk); #1;
      end
      do_reset();
      checks++;
      if (b_mem_timeout !== 1'b0) begin errors++; $display("FAIL watchdog_clear got %b exp 0", b_mem_timeout); end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout got no finish exp finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      apply(C_IDLE);
      test_reset();
      test_load_use();
      test_mem_wait();
      test_posted_store();
      test_overlap();
      test_watchdog();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
